// File: rtl/pipeline_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the 5-stage pipeline hazard controller.
//   state_e  : sequencer states (RUN, MC_WAIT)
//   NOP_CTRL : control word loaded into a latch when it is bubbled/flushed
//   REG_W    : architectural register-address width (16 registers)
// ---------------------------------------------------------------------------
package pipe_pkg;

  localparam int REG_W = 4;

  // A NOP is simply an all-zero control word: no writeback, no memory op.
  localparam logic [21:0] NOP_CTRL = 22'b0;

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_MC_WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Saturating up-counter used for the pipeline performance counters.
//   clk   : rising-edge clock
//   rst   : asynchronous reset, active-low (clears the count)
//   inc   : count this cycle
//   count : current value; sticks at all-ones instead of wrapping
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next value: step by one unless already saturated.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= {CNT_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Stall/flush sequencer for the IF/OF/EX/MA/RW pipeline. Resolves, in fixed
// priority, memory wait states, multicycle EX ops (start/done handshake with
// timeout), taken-branch squash and load-use hazards, and keeps saturating
// stall and flush counters.
// Inputs : clk, rst (async, active-low), OF source regs + valid mask, EX dest
//          reg and op class, branch outcome, MA memory request/ready, mc_done.
// Outputs: mc_start, hold_if/of/ex/ma, bubble_ex/ma/rw, flush_if_of,
//          pc_sel_br (all combinational, zero while in reset), mc_err
//          (sticky), stall_cnt, flush_cnt.
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_W  = 4,
  parameter int CNT_W  = 32,
  parameter int MC_TMO = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] of_rs1,
  input  logic [REG_W-1:0] of_rs2,
  input  logic [1:0]       of_rs_vld,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_is_ld,
  input  logic             ex_is_mc,
  input  logic             ex_br_taken,
  input  logic             ma_mem_req,
  input  logic             mem_ready,
  input  logic             mc_done,
  output logic             mc_start,
  output logic             hold_if,
  output logic             hold_of,
  output logic             hold_ex,
  output logic             hold_ma,
  output logic             bubble_ex,
  output logic             bubble_ma,
  output logic             bubble_rw,
  output logic             flush_if_of,
  output logic             pc_sel_br,
  output logic             mc_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int TMR_W = (MC_TMO > 2) ? $clog2(MC_TMO) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MC_TMO - 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

  state_e           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             err_q, err_d;

  logic mem_stall_s, load_use_s, mc_release_s;
  logic mc_start_s, hold_if_s, hold_of_s, hold_ex_s, hold_ma_s;
  logic bubble_ex_s, bubble_ma_s, bubble_rw_s, flush_s, pc_sel_s;

  // Hazard detection terms.
  always_comb begin
    mem_stall_s  = ma_mem_req & ~mem_ready;
    load_use_s   = ex_is_ld & ((of_rs_vld[0] & (of_rs1 == ex_rd)) |
                               (of_rs_vld[1] & (of_rs2 == ex_rd)));
    // A timeout releases EX exactly like a real completion would.
    mc_release_s = mc_done | (tmr_q == TMR_LAST);
  end

  // Priority mux for pipeline controls and next-state logic.
  always_comb begin
    mc_start_s  = 1'b0;
    hold_if_s   = 1'b0;
    hold_of_s   = 1'b0;
    hold_ex_s   = 1'b0;
    hold_ma_s   = 1'b0;
    bubble_ex_s = 1'b0;
    bubble_ma_s = 1'b0;
    bubble_rw_s = 1'b0;
    flush_s     = 1'b0;
    pc_sel_s    = 1'b0;
    state_d     = state_q;
    tmr_d       = tmr_q;
    err_d       = err_q;

    if (!rst) begin
      // Everything stays at its default (zero) while reset is asserted.
      state_d = ST_RUN;
    end else if (mem_stall_s) begin
      // Whole pipe freezes; only the multicycle timer keeps running
      // (saturating so it still fires once the memory releases).
      hold_if_s   = 1'b1;
      hold_of_s   = 1'b1;
      hold_ex_s   = 1'b1;
      hold_ma_s   = 1'b1;
      bubble_rw_s = 1'b1;
      if ((state_q == ST_MC_WAIT) && (tmr_q != TMR_LAST)) begin
        tmr_d = tmr_q + TMR_ONE;
      end else begin
        tmr_d = tmr_q;
      end
    end else begin
      case (state_q)
        ST_MC_WAIT: begin
          if (mc_release_s) begin
            state_d = ST_RUN;
            tmr_d   = {TMR_W{1'b0}};
            err_d   = err_q | ~mc_done;
          end else begin
            hold_if_s   = 1'b1;
            hold_of_s   = 1'b1;
            hold_ex_s   = 1'b1;
            bubble_ma_s = 1'b1;
            tmr_d       = tmr_q + TMR_ONE;
          end
        end
        ST_RUN: begin
          if (ex_is_mc) begin
            mc_start_s  = 1'b1;
            hold_if_s   = 1'b1;
            hold_of_s   = 1'b1;
            hold_ex_s   = 1'b1;
            bubble_ma_s = 1'b1;
            state_d     = ST_MC_WAIT;
            tmr_d       = {TMR_W{1'b0}};
          end else if (ex_br_taken) begin
            // Squashing OF makes any load-use hazard on it moot.
            flush_s  = 1'b1;
            pc_sel_s = 1'b1;
          end else if (load_use_s) begin
            hold_if_s   = 1'b1;
            hold_of_s   = 1'b1;
            bubble_ex_s = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d = ST_RUN;
          tmr_d   = {TMR_W{1'b0}};
        end
      endcase
    end
  end

  // Sequencer state, multicycle timer and sticky timeout flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      tmr_q   <= {TMR_W{1'b0}};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      err_q   <= err_d;
    end
  end

  assign mc_start    = mc_start_s;
  assign hold_if     = hold_if_s;
  assign hold_of     = hold_of_s;
  assign hold_ex     = hold_ex_s;
  assign hold_ma     = hold_ma_s;
  assign bubble_ex   = bubble_ex_s;
  assign bubble_ma   = bubble_ma_s;
  assign bubble_rw   = bubble_rw_s;
  assign flush_if_of = flush_s;
  assign pc_sel_br   = pc_sel_s;
  assign mc_err      = err_q;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (hold_if_s | hold_of_s | hold_ex_s | hold_ma_s),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_s),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Directed scenarios followed by a randomized run, all checked against a
// behavioural model of the hazard rules kept in this bench.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  localparam int REG_W  = 4;
  localparam int CNT_W  = 8;
  localparam int MC_TMO = 8;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic [REG_W-1:0] of_rs1, of_rs2, ex_rd;
  logic [1:0]       of_rs_vld;
  logic             ex_is_ld, ex_is_mc, ex_br_taken, ma_mem_req, mem_ready, mc_done;
  logic             mc_start, hold_if, hold_of, hold_ex, hold_ma;
  logic             bubble_ex, bubble_ma, bubble_rw, flush_if_of, pc_sel_br, mc_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  pipeline_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W), .MC_TMO(MC_TMO)) dut (
    .clk(clk), .rst(rst_n),
    .of_rs1(of_rs1), .of_rs2(of_rs2), .of_rs_vld(of_rs_vld), .ex_rd(ex_rd),
    .ex_is_ld(ex_is_ld), .ex_is_mc(ex_is_mc), .ex_br_taken(ex_br_taken),
    .ma_mem_req(ma_mem_req), .mem_ready(mem_ready), .mc_done(mc_done),
    .mc_start(mc_start), .hold_if(hold_if), .hold_of(hold_of), .hold_ex(hold_ex),
    .hold_ma(hold_ma), .bubble_ex(bubble_ex), .bubble_ma(bubble_ma),
    .bubble_rw(bubble_rw), .flush_if_of(flush_if_of), .pc_sel_br(pc_sel_br),
    .mc_err(mc_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: "is a multicycle op outstanding", how many
  // cycles it has waited, the sticky error and the two event totals.
  bit m_wait;
  int m_waited;
  bit m_err;
  int m_scnt, m_fcnt;
  int n_cmp, n_fail, n_start;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected controls, packed as
  // {mc_start, hold_if, hold_of, hold_ex, hold_ma, bubble_ex, bubble_ma, bubble_rw, flush, pc_sel}.
  function automatic logic [9:0] model_outs();
    bit mem, lu, waiting_more;
    mem = ma_mem_req && !mem_ready;
    lu  = ex_is_ld && ((of_rs_vld[0] && of_rs1 == ex_rd) || (of_rs_vld[1] && of_rs2 == ex_rd));
    waiting_more = m_wait && !mc_done && (m_waited < MC_TMO - 1);
    if (!rst_n)            return 10'b00000_00000;
    else if (mem)          return 10'b01111_00100;
    else if (waiting_more) return 10'b01110_01000;
    else if (m_wait)       return 10'b00000_00000;
    else if (ex_is_mc)     return 10'b11110_01000;
    else if (ex_br_taken)  return 10'b00000_00011;
    else if (lu)           return 10'b01100_10000;
    else                   return 10'b00000_00000;
  endfunction

  // One clock: check outputs mid low-phase, then advance the model at the edge.
  task automatic cycle();
    logic [9:0] e;
    #2;
    if (!rst_n) begin
      m_wait = 0; m_waited = 0; m_err = 0; m_scnt = 0; m_fcnt = 0;
    end
    e = model_outs();
    check("ctrl", {22'b0, mc_start, hold_if, hold_of, hold_ex, hold_ma,
                   bubble_ex, bubble_ma, bubble_rw, flush_if_of, pc_sel_br}, {22'b0, e});
    check("mc_err", {31'b0, mc_err}, {31'b0, m_err});
    check("stall_cnt", {24'b0, stall_cnt}, m_scnt);
    check("flush_cnt", {24'b0, flush_cnt}, m_fcnt);
    if (mc_start) n_start++;
    @(posedge clk);
    if (rst_n) begin
      if (e[8] && m_scnt < CMAX) m_scnt++;
      if (e[1] && m_fcnt < CMAX) m_fcnt++;
      if (ma_mem_req && !mem_ready) begin
        if (m_wait && m_waited < MC_TMO - 1) m_waited++;
      end else if (m_wait) begin
        if (mc_done) m_wait = 0;
        else if (m_waited >= MC_TMO - 1) begin m_wait = 0; m_err = 1; end
        else m_waited++;
      end else if (ex_is_mc) begin
        m_wait = 1; m_waited = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    of_rs1 = 4'd0; of_rs2 = 4'd0; of_rs_vld = 2'b00; ex_rd = 4'd0;
    ex_is_ld = 1'b0; ex_is_mc = 1'b0; ex_br_taken = 1'b0;
    ma_mem_req = 1'b0; mem_ready = 1'b1; mc_done = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; n_start = 0;
    m_wait = 0; m_waited = 0; m_err = 0; m_scnt = 0; m_fcnt = 0;
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    cycle();
    rst_n = 1'b1;
    cycle();

    // Load-use on rs1: one stall cycle.
    ex_is_ld = 1'b1; ex_rd = 4'd3; of_rs1 = 4'd3; of_rs_vld = 2'b01;
    cycle();
    idle_inputs();
    cycle();
    check("lu_stall_cnt", {24'b0, stall_cnt}, 32'd1);

    // Matching rs2 that is not enabled: no stall.
    ex_is_ld = 1'b1; ex_rd = 4'd3; of_rs1 = 4'd5; of_rs2 = 4'd3; of_rs_vld = 2'b01;
    cycle();
    idle_inputs();

    // Branch and load-use together: branch wins.
    ex_is_ld = 1'b1; ex_rd = 4'd3; of_rs1 = 4'd3; of_rs_vld = 2'b01; ex_br_taken = 1'b1;
    cycle();
    idle_inputs();
    cycle();
    check("br_flush_cnt", {24'b0, flush_cnt}, 32'd1);

    // Multicycle op completing after 5 wait cycles.
    n_start = 0;
    ex_is_mc = 1'b1;
    cycle();
    repeat (5) cycle();
    mc_done = 1'b1;
    cycle();
    idle_inputs();
    cycle();
    check("mc_start_once", n_start, 32'd1);
    check("mc_stall_cnt", {24'b0, stall_cnt}, 32'd7);

    // Memory wait states in the middle of MC_WAIT.
    ex_is_mc = 1'b1;
    cycle();
    repeat (2) cycle();
    ma_mem_req = 1'b1; mem_ready = 1'b0;
    repeat (3) cycle();
    mem_ready = 1'b1;
    cycle();
    mc_done = 1'b1;
    cycle();
    idle_inputs();
    cycle();

    // Timeout: no mc_done ever arrives.
    ex_is_mc = 1'b1;
    cycle();
    repeat (MC_TMO) cycle();
    idle_inputs();
    cycle();
    check("tmo_err", {31'b0, mc_err}, 32'd1);
    // mc_done while in RUN is ignored.
    mc_done = 1'b1;
    cycle();
    idle_inputs();

    // Reset in the middle of a multicycle stall.
    ex_is_mc = 1'b1;
    cycle();
    repeat (2) cycle();
    rst_n = 1'b0;
    #1;
    check("rst_holds", {28'b0, hold_if, hold_of, hold_ex, bubble_ma}, 32'd0);
    @(negedge clk);
    cycle();
    idle_inputs();
    rst_n = 1'b1;
    n_start = 0;
    cycle();
    check("no_restart", n_start, 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      of_rs1      = 4'($urandom_range(0, 3));
      of_rs2      = 4'($urandom_range(0, 3));
      ex_rd       = 4'($urandom_range(0, 3));
      of_rs_vld   = 2'($urandom_range(0, 3));
      ex_is_ld    = ($urandom_range(0, 2) == 0);
      ex_is_mc    = m_wait ? 1'b1 : ($urandom_range(0, 11) == 0);
      ex_br_taken = ($urandom_range(0, 5) == 0);
      ma_mem_req  = ($urandom_range(0, 2) == 0);
      mem_ready   = ($urandom_range(0, 1) == 0);
      mc_done     = ($urandom_range(0, 5) == 0);
      rst_n       = ($urandom_range(0, 399) != 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
